// File: rtl/nibble_addsub_arbiter.sv
// Purpose: two-requester round-robin front end for one shared 4-bit add/sub slice, sequenced nibble-serially.
// Latency: grant edge + NIBBLES CALC edges, then one DONE cycle (done pulse); one op per NIBBLES+2 cycles.
// Backpressure: requests are only granted in IDLE; requesters hold req until gnt, and a dropped req is not served.
//
// Ports:
//   clk, rst            rising-edge clock, asynchronous active-high reset
//   req0/req1           request lines, held by the requester until granted
//   sub0/sub1           0 = a+b, 1 = a-b
//   a0,b0 / a1,b1       W-bit operands, sampled on the grant edge only
//   gnt0/gnt1           combinational grant, high only in IDLE for the winner
//   busy                engine not in IDLE
//   done, done_id       one-cycle result-valid pulse and owning requester
//   result, cout, ovf   W-bit result, carry (subtract: 1 = no borrow), signed overflow
module nibble_addsub_arbiter #(
  parameter int NIBBLES = 4,
  localparam int W = 4 * NIBBLES
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         req0,
  input  logic         req1,
  input  logic         sub0,
  input  logic         sub1,
  input  logic [W-1:0] a0,
  input  logic [W-1:0] b0,
  input  logic [W-1:0] a1,
  input  logic [W-1:0] b1,
  output logic         gnt0,
  output logic         gnt1,
  output logic         busy,
  output logic         done,
  output logic         done_id,
  output logic [W-1:0] result,
  output logic         cout,
  output logic         ovf
);

  localparam int CW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] CALC = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]    state;
  logic [CW-1:0] cnt;
  logic          last_id;
  logic          id;
  logic          carry;
  // Operands shift right one nibble per CALC cycle so the slice always sees bits [3:0];
  // the partial result shifts in from the top and is fully aligned after NIBBLES steps.
  logic [W-1:0]  areg;
  logic [W-1:0]  breg;
  logic [W-1:0]  racc;

  logic          any_req;
  logic          sel;
  logic          grant_ok;
  logic          sel_sub;
  logic [W-1:0]  sel_a;
  logic [W-1:0]  sel_b;
  logic [4:0]    nib_sum;
  logic [W+3:0]  racc_ext;
  logic [W-1:0]  racc_next;
  logic          last_nib;

  always_comb begin
    any_req = req0 | req1;
    // On a tie the requester that did not win last time goes; otherwise the lone requester.
    sel      = (req0 && req1) ? ~last_id : req1;
    grant_ok = (state == IDLE) && !rst && any_req;
    gnt0     = grant_ok && !sel;
    gnt1     = grant_ok && sel;
    sel_sub  = sel ? sub1 : sub0;
    sel_a    = sel ? a1 : a0;
    sel_b    = sel ? b1 : b0;
  end

  always_comb begin
    nib_sum   = {1'b0, areg[3:0]} + {1'b0, breg[3:0]} + {4'b0000, carry};
    racc_ext  = {nib_sum[3:0], racc};
    racc_next = racc_ext[W+3:4];
    last_nib  = (cnt == CW'(NIBBLES - 1));
  end

  assign busy = (state != IDLE);
  assign done = (state == DONE);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      last_id <= 1'b1;
      id      <= 1'b0;
      carry   <= 1'b0;
      areg    <= '0;
      breg    <= '0;
      racc    <= '0;
      result  <= '0;
      cout    <= 1'b0;
      ovf     <= 1'b0;
      done_id <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (any_req) begin
            // Subtract is a + ~b + 1: invert b here and seed the carry with 1.
            areg    <= sel_a;
            breg    <= sel_sub ? ~sel_b : sel_b;
            carry   <= sel_sub;
            id      <= sel;
            last_id <= sel;
            cnt     <= '0;
            racc    <= '0;
            state   <= CALC;
          end
        end
        CALC: begin
          areg  <= areg >> 4;
          breg  <= breg >> 4;
          racc  <= racc_next;
          carry <= nib_sum[4];
          cnt   <= cnt + 1'b1;
          if (last_nib) begin
            // On the final nibble areg[3]/breg[3] are the original operand sign bits.
            result  <= racc_next;
            cout    <= nib_sum[4];
            ovf     <= (areg[3] == breg[3]) && (nib_sum[3] != areg[3]);
            done_id <= id;
            cnt     <= '0;
            state   <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_addsub_arbiter.sv
// Purpose: self-checking bench for nibble_addsub_arbiter against an arithmetic reference model.
// Latency: each transaction is checked cycle by cycle from grant through the DONE cycle.
// Backpressure: requests are held or dropped per scenario; grants are checked never to overlap busy.
module tb_nibble_addsub_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0, req1, sub0, sub1;
  logic [15:0] a0, b0, a1, b1;
  logic        gnt0, gnt1, busy, done, done_id, cout, ovf;
  logic [15:0] result;

  int n_checks = 0;
  int n_pass   = 0;
  bit m_last   = 1'b1;

  nibble_addsub_arbiter #(.NIBBLES(4)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .req1(req1), .sub0(sub0), .sub1(sub1),
    .a0(a0), .b0(b0), .a1(a1), .b1(b1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .done(done), .done_id(done_id),
    .result(result), .cout(cout), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Reference arithmetic: plain W-bit add/subtract with flags from the operand signs.
  task automatic ref_op(input bit s, input logic [15:0] a, input logic [15:0] b,
                        output logic [15:0] r, output bit c, output bit v);
    logic [31:0] full;
    if (!s) begin
      full = 32'(a) + 32'(b);
      r = full[15:0];
      c = full[16];
      v = (a[15] == b[15]) && (r[15] != a[15]);
    end else begin
      r = a - b;
      c = (a >= b);
      v = (a[15] != b[15]) && (r[15] != a[15]);
    end
  endtask

  task automatic scramble;
    a0 = 16'($urandom); b0 = 16'($urandom); a1 = 16'($urandom); b1 = 16'($urandom);
    sub0 = 1'($urandom); sub1 = 1'($urandom);
  endtask

  // Entered one time unit after a rising edge with the engine idle and requests already driven.
  task automatic run_txn(input string tag, input bit hold);
    bit          w, ec, ev;
    logic [15:0] er;
    if (req0 && req1) w = ~m_last;
    else              w = req1;
    if (w) ref_op(sub1, a1, b1, er, ec, ev);
    else   ref_op(sub0, a0, b0, er, ec, ev);
    #1;
    check({tag, ".gnt0"}, gnt0, !w);
    check({tag, ".gnt1"}, gnt1, w);
    check({tag, ".idle"}, busy, 0);
    tick;
    m_last = w;
    check({tag, ".busy_e0"}, busy, 1);
    check({tag, ".nognt_e0"}, {gnt0, gnt1}, 0);
    if (!hold) begin
      req0 = 1'b0;
      req1 = 1'b0;
    end
    scramble;
    for (int i = 1; i <= 3; i++) begin
      tick;
      check($sformatf("%s.nodone_e%0d", tag, i), done, 0);
      check($sformatf("%s.nognt_e%0d", tag, i), {gnt0, gnt1}, 0);
    end
    tick;
    check({tag, ".done"}, done, 1);
    check({tag, ".done_id"}, done_id, w);
    check({tag, ".result"}, result, er);
    check({tag, ".cout"}, cout, ec);
    check({tag, ".ovf"}, ovf, ev);
    check({tag, ".busy_done"}, busy, 1);
    check({tag, ".nognt_done"}, {gnt0, gnt1}, 0);
    tick;
    check({tag, ".done_off"}, done, 0);
    check({tag, ".busy_off"}, busy, 0);
    check({tag, ".result_held"}, result, er);
  endtask

  task automatic drive(input bit who, input bit s, input logic [15:0] a, input logic [15:0] b);
    req0 = !who;
    req1 = who;
    if (who) begin sub1 = s; a1 = a; b1 = b; end
    else     begin sub0 = s; a0 = a; b0 = b; end
  endtask

  initial begin
    rst = 1'b1;
    req0 = 0; req1 = 0; sub0 = 0; sub1 = 0;
    a0 = 0; b0 = 0; a1 = 0; b1 = 0;
    #2;
    check("rst.outs", {gnt0, gnt1, busy, done, done_id, cout, ovf}, 0);
    check("rst.result", result, 0);
    tick;
    tick;
    rst = 1'b0;
    #1;
    check("rst.idle", {busy, done, gnt0, gnt1}, 0);

    drive(0, 0, 16'h0001, 16'h0001); run_txn("add_1_1", 0);
    drive(1, 1, 16'h0003, 16'h0001); run_txn("sub_3_1", 0);
    drive(1, 1, 16'h0004, 16'h0006); run_txn("sub_4_6", 0);
    drive(0, 0, 16'hFFFF, 16'h0001); run_txn("add_ffff_1", 0);
    drive(0, 0, 16'h7FFF, 16'h0001); run_txn("add_7fff_1", 0);
    drive(1, 1, 16'h8000, 16'h0001); run_txn("sub_8000_1", 0);
    drive(1, 1, 16'h0000, 16'h0000); run_txn("sub_0_0", 0);

    for (int t = 0; t < 24; t++) begin
      logic [1:0] r;
      r = 2'($urandom_range(1, 3));
      scramble;
      req0 = r[0];
      req1 = r[1];
      run_txn($sformatf("rnd%0d", t), 0);
    end

    // Continuous contention: grants must alternate, one every six cycles.
    req0 = 1'b1;
    req1 = 1'b1;
    scramble;
    for (int t = 0; t < 4; t++) run_txn($sformatf("cont%0d", t), 1);
    req0 = 1'b0;
    req1 = 1'b0;

    // Reset during the second CALC cycle aborts the operation.
    drive(0, 0, 16'h1234, 16'h4321);
    #1;
    tick;
    req0 = 1'b0;
    tick;
    rst = 1'b1;
    #1;
    check("abort.outs", {gnt0, gnt1, busy, done, done_id, cout, ovf}, 0);
    check("abort.result", result, 0);
    req0 = 1'b1;
    req1 = 1'b1;
    #1;
    check("abort.nognt", {gnt0, gnt1}, 0);
    for (int i = 0; i < 3; i++) begin
      tick;
      check($sformatf("abort.nodone%0d", i), {done, busy}, 0);
    end
    rst = 1'b0;
    m_last = 1'b1;
    run_txn("post_rst", 0);
    check("post_rst.winner0", done_id, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
